conv2_seq_ctrl: RTL
===================

# conv2_seq_ctrl

Sequential controller for the second convolution layer: a stride-1, zero-padded 27×27×96 input convolved with a 5×5×96 kernel. It replaces the fully unrolled combinational datapath with a single time-shared multiply-accumulate unit. It walks every output position, kernel tap and channel, issues reads to the input-feature and kernel buffers, accumulates, and writes each 16-bit result to the output buffer under a ready/valid handshake.

## Interface
Parameters:
- IN_H, 27, input feature height
- IN_W, 27, input feature width
- CH, 96, input channels
- K, 5, kernel side
- PAD, 2, zero padding on each side
- DATA_W, 16, data and accumulator width
- Derived: OUT_H = IN_H+2·PAD−K+1, OUT_W = IN_W+2·PAD−K+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a full layer pass
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse when the last output is accepted
- in_rd_en  out  1  input buffer read strobe
- in_addr  out  clog2(IN_H·IN_W·CH)  address = (row·IN_W+col)·CH+ch
- in_rdata  in  DATA_W  read data, valid exactly 1 cycle after in_rd_en
- k_rd_en  out  1  kernel buffer read strobe
- k_addr  out  clog2(K·K·CH)  address = (m·K+n)·CH+ch
- k_rdata  in  DATA_W  read data, valid exactly 1 cycle after k_rd_en
- out_valid  out  1  output word valid
- out_ready  in  1  output buffer accepts the word
- out_addr  out  clog2(OUT_H·OUT_W)  address = i·OUT_W+j
- out_data  out  DATA_W  convolution result

## Operation
- FSM states:
  - IDLE: start → RUN. Clear the accumulator and the counters i, j, m, n, ch.
  - RUN: issue one tap per cycle. Loop order is i, j (outer), then m, n, ch (ch innermost). After the last tap (m=n=K−1, ch=CH−1) → DRAIN.
  - DRAIN: one cycle to absorb the last read's data → WRITE.
  - WRITE: hold out_valid=1 with out_addr and out_data stable until out_ready=1.
    - On acceptance, if (i, j) is the last output position → DONE.
    - Otherwise advance (i, j), clear the accumulator and go to RUN.
  - DONE: done=1 for one cycle → IDLE.
- Padding:
  - Compute r = i+m−PAD and c = j+n−PAD.
  - If r∉[0,IN_H) or c∉[0,IN_W), the tap is a padded tap: in_rd_en=0 and k_rd_en=0, and a tagged bubble propagates down the pipeline, so the tap contributes 0.
  - The cycle is still consumed, which keeps latency deterministic.
- Arithmetic:
  - product = low DATA_W bits of in_rdata × k_rdata (unsigned).
  - The accumulator wraps modulo 2^DATA_W.
  - The result is therefore bit-exact to an unrolled sum truncated at 16 bits.
- start is ignored while busy=1.
- Read addresses are don't-care when the corresponding enable is low.

## Timing
- Reset values: busy=0, done=0, in_rd_en=0, k_rd_en=0, out_valid=0; all addresses and out_data = 0; state = IDLE.
- start sampled high in IDLE → busy=1 and the first reads are issued in the next cycle.
- Pipeline: read issued in cycle t, data arrives in t+1, the MAC updates the accumulator at the end of t+1.
- Per output: K·K·CH RUN cycles, plus 1 DRAIN cycle, plus at least 1 WRITE cycle. With default parameters and out_ready tied high this is 2402 cycles.
- Full pass with out_ready tied high: OUT_H·OUT_W·2402 = 1,751,058 cycles from start to done.
- busy falls in the same cycle that done pulses.
- Backpressure: out_ready low stalls only in WRITE; no reads are issued while stalled.
- Asynchronous reset mid-pass aborts immediately: all outputs return to reset values, the partial result is discarded, and no write completes.

## Structure
- Package conv2_pkg holds:
  - the geometry parameters and the derived OUT_H/OUT_W;
  - the address widths, as localparams computed with $clog2;
  - the state enum: IDLE, RUN, DRAIN, WRITE, DONE.
- Sub-module conv2_mac: registered valid/bubble tag, truncating multiply, wrapping accumulate, synchronous clear.
- The top level holds the FSM, the five loop counters, the padding check and the address generation.

## Test plan
1. Small config (IN_H=IN_W=3, CH=2, K=3, PAD=1), all inputs 1, all kernels 1, out_ready=1 → results:
   - corners 8, edges 12, centre 18;
   - out_addr runs 0..8 in order;
   - done exactly 9·(18+2)=180 cycles after start.
2. Default config, a single input pixel (13,13,ch0)=3 and kernel tap (2,2,ch0)=5, all else 0 → out_data=15 at out_addr 13·27+13 only; every other output is 0.
3. Overflow: default config with all values 0x0100 → every product truncates to 0, so every output is 0. Then all inputs 0x00FF and kernels 0x0101 → centre output = (2400·0xFFFF) mod 2^16 = 0xF6A0.
4. Backpressure: random out_ready with 30% high → out_data and out_addr stay stable while out_valid=1 and out_ready=0; results and ordering match test 1.
5. Padding: check that in_rd_en is never asserted with an out-of-range row or col; small config issues exactly 2·(4·4+4·6+9)=98 real reads per pass.
6. Control: start pulsed while busy → ignored. rst_n asserted mid-RUN → all outputs 0 asynchronously. A fresh start after reset produces the full correct pass.

Source files
------------

// File: rtl/conv2_pkg.sv
// Shared geometry, address widths and FSM state encoding for the layer-2 convolution controller.
`timescale 1ns/1ps
package conv2_pkg;

  localparam int DEF_IN_H   = 27;
  localparam int DEF_IN_W   = 27;
  localparam int DEF_CH     = 96;
  localparam int DEF_K      = 5;
  localparam int DEF_PAD    = 2;
  localparam int DEF_DATA_W = 16;

  localparam int DEF_OUT_H = DEF_IN_H + 2*DEF_PAD - DEF_K + 1;
  localparam int DEF_OUT_W = DEF_IN_W + 2*DEF_PAD - DEF_K + 1;

  localparam int DEF_IN_AW  = $clog2(DEF_IN_H*DEF_IN_W*DEF_CH);
  localparam int DEF_K_AW   = $clog2(DEF_K*DEF_K*DEF_CH);
  localparam int DEF_OUT_AW = $clog2(DEF_OUT_H*DEF_OUT_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2_mac.sv
// Time-shared multiply-accumulate: one tap per cycle, bubble-tagged, wrapping DATA_W-bit sum.
`timescale 1ns/1ps
module conv2_mac
  import conv2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_tag,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_acc
);

  logic              r_tag;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // Product evaluated in DATA_W context, so only the low bits survive.
  assign w_prod = i_a * i_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= 1'b0;
      r_acc <= '0;
    end else begin
      r_tag <= i_tag;
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_tag) begin
        r_acc <= r_acc + w_prod;
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/conv2_seq_ctrl.sv
// Sequential conv layer-2 controller: walks (i,j,m,n,ch), skips padded taps, writes one
// accumulated word per output position over a ready/valid port.
`timescale 1ns/1ps
module conv2_seq_ctrl
  import conv2_pkg::*;
#(
  parameter  int IN_H   = DEF_IN_H,
  parameter  int IN_W   = DEF_IN_W,
  parameter  int CH     = DEF_CH,
  parameter  int K      = DEF_K,
  parameter  int PAD    = DEF_PAD,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int OUT_H  = IN_H + 2*PAD - K + 1,
  localparam int OUT_W  = IN_W + 2*PAD - K + 1,
  localparam int IN_AW  = $clog2(IN_H*IN_W*CH),
  localparam int K_AW   = $clog2(K*K*CH),
  localparam int OUT_AW = $clog2(OUT_H*OUT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_in_rd_en,
  output logic [IN_AW-1:0]  o_in_addr,
  input  logic [DATA_W-1:0] i_in_rdata,
  output logic              o_k_rd_en,
  output logic [K_AW-1:0]   o_k_addr,
  input  logic [DATA_W-1:0] i_k_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data
);

  localparam int I_W  = cw(OUT_H);
  localparam int J_W  = cw(OUT_W);
  localparam int M_W  = cw(K);
  localparam int CH_W = cw(CH);
  localparam int S_W  = cw(OUT_H + OUT_W + 2*K + IN_H + IN_W + 2*PAD) + 1;

  state_t r_state;
  state_t w_state_next;

  logic [I_W-1:0]  r_i;
  logic [J_W-1:0]  r_j;
  logic [M_W-1:0]  r_m;
  logic [M_W-1:0]  r_n;
  logic [CH_W-1:0] r_ch;

  logic              w_last_tap;
  logic              w_last_pos;
  logic              w_row_ok;
  logic              w_col_ok;
  logic              w_tap_real;
  logic              w_acc_clr;
  logic [S_W-1:0]    w_row_sum;
  logic [S_W-1:0]    w_col_sum;
  logic [IN_AW-1:0]  w_row;
  logic [IN_AW-1:0]  w_col;
  logic [IN_AW-1:0]  w_in_lin;
  logic [K_AW-1:0]   w_k_lin;
  logic [DATA_W-1:0] w_acc;

  assign w_last_tap = (r_m == M_W'(K-1)) && (r_n == M_W'(K-1)) && (r_ch == CH_W'(CH-1));
  assign w_last_pos = (r_i == I_W'(OUT_H-1)) && (r_j == J_W'(OUT_W-1));

  // Padding test on the unshifted sums i+m and j+n avoids signed arithmetic.
  assign w_row_sum = S_W'(r_i) + S_W'(r_m);
  assign w_col_sum = S_W'(r_j) + S_W'(r_n);
  assign w_row_ok  = (w_row_sum >= S_W'(PAD)) && (w_row_sum < S_W'(IN_H + PAD));
  assign w_col_ok  = (w_col_sum >= S_W'(PAD)) && (w_col_sum < S_W'(IN_W + PAD));

  assign w_row    = IN_AW'(r_i) + IN_AW'(r_m) - IN_AW'(PAD);
  assign w_col    = IN_AW'(r_j) + IN_AW'(r_n) - IN_AW'(PAD);
  assign w_in_lin = (w_row * IN_AW'(IN_W) + w_col) * IN_AW'(CH) + IN_AW'(r_ch);
  assign w_k_lin  = (K_AW'(r_m) * K_AW'(K) + K_AW'(r_n)) * K_AW'(CH) + K_AW'(r_ch);

  assign o_in_rd_en = w_tap_real;
  assign o_k_rd_en  = w_tap_real;
  assign o_in_addr  = w_tap_real ? w_in_lin : '0;
  assign o_k_addr   = w_tap_real ? w_k_lin  : '0;
  assign o_out_addr = OUT_AW'(r_i) * OUT_AW'(OUT_W) + OUT_AW'(r_j);
  assign o_out_data = w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_out_valid  = 1'b0;
    w_tap_real   = 1'b0;
    w_acc_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_RUN;
          w_acc_clr    = 1'b1;
        end
      end
      ST_RUN: begin
        o_busy     = 1'b1;
        w_tap_real = w_row_ok && w_col_ok;
        if (w_last_tap) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy       = 1'b1;
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_acc_clr    = 1'b1;
          w_state_next = w_last_pos ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Tap counters wrap to zero on the last tap, so RUN always re-enters at m=n=ch=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i  <= '0;
      r_j  <= '0;
      r_m  <= '0;
      r_n  <= '0;
      r_ch <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_i  <= '0;
            r_j  <= '0;
            r_m  <= '0;
            r_n  <= '0;
            r_ch <= '0;
          end
        end
        ST_RUN: begin
          if (r_ch == CH_W'(CH-1)) begin
            r_ch <= '0;
            if (r_n == M_W'(K-1)) begin
              r_n <= '0;
              if (r_m == M_W'(K-1)) begin
                r_m <= '0;
              end else begin
                r_m <= r_m + M_W'(1);
              end
            end else begin
              r_n <= r_n + M_W'(1);
            end
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        ST_WRITE: begin
          if (i_out_ready && !w_last_pos) begin
            if (r_j == J_W'(OUT_W-1)) begin
              r_j <= '0;
              r_i <= r_i + I_W'(1);
            end else begin
              r_j <= r_j + J_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  conv2_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_acc_clr),
    .i_tag (w_tap_real),
    .i_a   (i_in_rdata),
    .i_b   (i_k_rdata),
    .o_acc (w_acc)
  );

endmodule
